sig_echo: RTL and testbench
===========================

// Module: sig_echo
// PURPOSE
//  Parametrised successor to the signal-delay path: circular-buffer delay line with runtime delay,
//  three modes (pure delay, feedback echo, bypass), a valid strobe and a primed flag.
//  Sits between the sample source (mic/sinegen) and the output/plot path.
//  Samples are signed two's complement. Fixed 2-cycle latency. One sample accepted per cycle.
// PARAMETERS
//  A_WIDTH   9   buffer address width; depth = 2**A_WIDTH; max delay = 2**A_WIDTH-1
//  D_WIDTH   8   sample width (signed)
//  G_WIDTH   3   width of gain_shift (feedback attenuation = >>> gain_shift)
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  rst         in   1         synchronous, active-high reset
//  en          in   1         block enable; gates acceptance of new samples
//  in_valid    in   1         din valid this cycle; accepted when en && in_valid
//  mode        in   2         sig_echo_pkg::mode_t: MODE_DELAY=0, MODE_ECHO=1, MODE_BYPASS=2 (3 = bypass)
//  delay       in   A_WIDTH   tap distance in accepted samples; sampled at acceptance
//  gain_shift  in   G_WIDTH   echo attenuation shift; sampled at acceptance
//  din         in   D_WIDTH   input sample
//  dout        out  D_WIDTH   output sample, registered
//  out_valid   out  1         dout valid; single-cycle pulse per accepted sample
//  primed      out  1         high once fill_cnt >= delay (tap reads real history)
// BEHAVIOUR
//  - Reset: wr_ptr=0, fill_cnt=0, dout=0, out_valid=0, primed=0, pipeline valids=0. RAM not cleared.
//  - Reset mid-operation: in-flight samples dropped, no out_valid, no RAM write after reset edge.
//  - Accept at edge T (en&&in_valid): capture din/mode/delay/gain_shift into stage 1;
//    issue RAM read at rd_addr = wr_ptr - delay (mod 2**A_WIDTH; wrap is natural);
//    latch wa = wr_ptr; wr_ptr <= wr_ptr+1.
//  - Edge T+1: tap = RAM dout (1-cycle read latency), masked/forwarded per rules below;
//    dout <= result; out_valid <= 1; RAM[wa] <= wb; fill_cnt <= sat_inc(fill_cnt).
//  - Latency: in_valid at edge T -> dout/out_valid visible after edge T+1 (2 cycles).
//  - Mode results (sum in D_WIDTH+1 bits, saturate to [-2**(D-1), 2**(D-1)-1]):
//      DELAY : result = tap;                          wb = din
//      ECHO  : result = sat(din + (tap >>> gain_shift)); wb = result (feedback)
//      BYPASS: result = din;                          wb = din (history kept live)
//  - Warm-up mask: if fill_cnt (at acceptance) < delay, tap = 0. fill_cnt saturates at 2**A_WIDTH-1.
//    primed = (fill_cnt >= current delay input), registered.
//  - delay==0: tap = din of the same sample (DELAY -> dout=din; ECHO -> din + din>>>g, saturated).
//  - Hazard: back-to-back accepts with delay==1 read the address written at the same edge;
//    forward stage-1 wb into tap. No other delay value collides.
//  - en low or in_valid low: no accept, wr_ptr/fill_cnt hold; in-flight stage 1 still completes.
//  - delay/mode change between samples takes effect on the next accepted sample; no flush.
//  - Simultaneous rst and accept: rst wins.
// STRUCTURE
//  - sig_echo_pkg: mode_t enum (2 bits), MODE_* constants, sat_add function (parametrised by width).
//  - Sub-module: existing ram2ports (1 write, 1 read port, registered read) for the buffer.
//  - Top holds pointer counter, fill counter, stage-1 regs, forward mux, mix/saturate, output regs.
// TESTING
//  1 Reset: rst high 3 cycles with in_valid=1 -> dout=0, out_valid=0, primed=0 throughout.
//  2 DELAY, delay=4, ramp din=1..10 one per cycle -> dout 0,0,0,0,1,2..6 at 2-cycle latency; primed rises after 4th write.
//  3 ECHO, delay=1, gain_shift=1, impulse din=64 then 0s back-to-back -> dout 64,32,16,8,4,2,1,0 (forward path).
//  4 Saturation: ECHO, delay=0, gain_shift=0, din=100 -> dout=127; din=-100 -> dout=-128.
//  5 Wrap: A_WIDTH=4, DELAY, delay=15, 40 ramp samples -> dout[n]=din[n-15] across pointer wrap; delay=0 -> dout=din.
//  6 Gaps/en: in_valid every 3rd cycle and en toggled -> outputs per accepted sample only; rst mid-stream -> no out_valid from dropped sample.

Source files
------------

// File: rtl/sig_echo_pkg.sv
// rtl/sig_echo_pkg.sv - shared types, defaults and saturating add for the echo delay line
package sig_echo_pkg;

    localparam int A_WIDTH_DEF = 9;
    localparam int D_WIDTH_DEF = 8;
    localparam int G_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        MODE_DELAY   = 2'd0,
        MODE_ECHO    = 2'd1,
        MODE_BYPASS  = 2'd2,
        MODE_BYPASS3 = 2'd3
    } mode_t;

    // Operands arrive sign-extended to 32 bits; result is clamped to a signed width-bit range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 width
    );
        logic signed [31:0] sum;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        sum   = a + b;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sig_echo_ram2ports.sv
// rtl/sig_echo_ram2ports.sv - one write, one registered read port buffer RAM
module sig_echo_ram2ports #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Read returns the old contents when the same address is written on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sig_echo.sv
// rtl/sig_echo.sv - circular-buffer delay line with delay, echo and bypass modes
module sig_echo
    import sig_echo_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int G_WIDTH = G_WIDTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_in_valid,
    input  mode_t                     i_mode,
    input  logic [A_WIDTH-1:0]        i_delay,
    input  logic [G_WIDTH-1:0]        i_gain_shift,
    input  logic signed [D_WIDTH-1:0] i_din,
    output logic signed [D_WIDTH-1:0] o_dout,
    output logic                      o_out_valid,
    output logic                      o_primed
);

    logic [A_WIDTH-1:0]        r_wr_ptr;
    logic [A_WIDTH-1:0]        r_fill;
    logic                      r_s1_valid;
    logic signed [D_WIDTH-1:0] r_s1_din;
    mode_t                     r_s1_mode;
    logic [G_WIDTH-1:0]        r_s1_gain;
    logic [A_WIDTH-1:0]        r_s1_wa;
    logic                      r_s1_mask;
    logic                      r_s1_self;
    logic                      r_s1_fwd;
    logic signed [D_WIDTH-1:0] r_fwd_data;
    logic signed [D_WIDTH-1:0] r_dout;
    logic                      r_out_valid;
    logic                      r_primed;

    logic                      w_accept;
    logic                      w_we;
    logic [A_WIDTH-1:0]        w_rd_addr;
    logic [D_WIDTH-1:0]        w_rdata;
    logic signed [D_WIDTH-1:0] w_tap;
    logic signed [D_WIDTH-1:0] w_shifted;
    logic signed [D_WIDTH-1:0] w_echo;
    logic signed [D_WIDTH-1:0] w_result;
    logic signed [D_WIDTH-1:0] w_wb;

    assign w_accept  = i_en && i_in_valid;
    assign w_rd_addr = r_wr_ptr - i_delay;
    // The reset edge must not commit the sample that was in flight.
    assign w_we      = r_s1_valid && !i_rst;

    sig_echo_ram2ports #(
        .AW (A_WIDTH),
        .DW (D_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_s1_wa),
        .i_wdata (w_wb),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_tap = '0;
        if (!r_s1_mask) begin
            if (r_s1_self) begin
                w_tap = r_s1_din;
            end else if (r_s1_fwd) begin
                w_tap = r_fwd_data;
            end else begin
                w_tap = $signed(w_rdata);
            end
        end
        w_shifted = w_tap >>> r_s1_gain;
        w_echo    = D_WIDTH'(sat_add(32'(r_s1_din), 32'(w_shifted), D_WIDTH));
        w_result  = r_s1_din;
        w_wb      = r_s1_din;
        case (r_s1_mode)
            MODE_DELAY: w_result = w_tap;
            MODE_ECHO: begin
                w_result = w_echo;
                w_wb     = w_echo;
            end
            default: w_result = r_s1_din;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_s1_valid  <= 1'b0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_s1_valid  <= w_accept;
            r_out_valid <= r_s1_valid;
            r_primed    <= (r_fill >= i_delay);
            if (r_s1_valid) begin
                r_dout <= w_result;
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_fill != '1) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // With delay 1 back-to-back, the tap address is being written this very edge: forward it.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_s1_din   <= i_din;
            r_s1_mode  <= i_mode;
            r_s1_gain  <= i_gain_shift;
            r_s1_wa    <= r_wr_ptr;
            r_s1_mask  <= (r_fill < i_delay);
            r_s1_self  <= (i_delay == '0);
            r_s1_fwd   <= (i_delay == A_WIDTH'(1)) && r_s1_valid;
            r_fwd_data <= w_wb;
        end
    end

    assign o_dout      = r_dout;
    assign o_out_valid = r_out_valid;
    assign o_primed    = r_primed;

endmodule

// File: tb/tb_sig_echo.sv
// tb/tb_sig_echo.sv - directed self-checking bench for sig_echo
module tb_sig_echo;
    import sig_echo_pkg::*;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic              i_in_valid;
    mode_t             i_mode;
    logic [3:0]        i_delay;
    logic [2:0]        i_gain_shift;
    logic signed [7:0] i_din;
    logic signed [7:0] o_dout;
    logic              o_out_valid;
    logic              o_primed;

    int vectors = 0;
    int miscompares = 0;
    logic signed [7:0] q[$];

    always #5 clk = ~clk;

    sig_echo #(.A_WIDTH(4), .D_WIDTH(8), .G_WIDTH(3)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_in_valid   (i_in_valid),
        .i_mode       (i_mode),
        .i_delay      (i_delay),
        .i_gain_shift (i_gain_shift),
        .i_din        (i_din),
        .o_dout       (o_dout),
        .o_out_valid  (o_out_valid),
        .o_primed     (o_primed)
    );

    always @(negedge clk) begin
        if (o_out_valid) q.push_back(o_dout);
    end

    task automatic apply(input logic v, input logic e, input logic signed [7:0] d);
        i_in_valid = v;
        i_en       = e;
        i_din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        apply(1'b0, 1'b0, 8'sd0);
        apply(1'b0, 1'b0, 8'sd0);
        i_rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        i_mode = MODE_DELAY; i_delay = 4'd0; i_gain_shift = 3'd0;
        i_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 8'sd55);
            vectors++;
            if (o_dout !== 8'sd0 || o_out_valid !== 1'b0 || o_primed !== 1'b0) begin
                miscompares++;
                $display("FAIL reset c%0d: dout=%0d valid=%b primed=%b, required 0/0/0", c, o_dout, o_out_valid, o_primed);
            end
        end
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 8'sd0);
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_no_output: outputs=%0d, required 0", q.size());
        end
    endtask

    task automatic test_delay_ramp();
        logic signed [7:0] exp2 [10] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6};
        i_mode = MODE_DELAY; i_delay = 4'd4; i_gain_shift = 3'd0;
        pulse_reset();
        for (int k = 1; k <= 10; k++) begin
            apply(1'b1, 1'b1, 8'(k));
            vectors++;
            if (o_out_valid !== (k >= 2) || o_primed !== (k >= 5)) begin
                miscompares++;
                $display("FAIL ramp_flags k%0d: valid=%b primed=%b, required %b/%b", k, o_out_valid, o_primed, k >= 2, k >= 5);
            end
            if (k >= 2) begin
                vectors++;
                if (o_dout !== exp2[k-2]) begin
                    miscompares++;
                    $display("FAIL ramp_dout k%0d: dout=%0d, required %0d", k, o_dout, exp2[k-2]);
                end
            end
        end
        apply(1'b0, 1'b1, 8'sd0);
        vectors++;
        if (o_out_valid !== 1'b1 || o_dout !== exp2[9]) begin
            miscompares++;
            $display("FAIL ramp_last: valid=%b dout=%0d, required 1/%0d", o_out_valid, o_dout, exp2[9]);
        end
        apply(1'b0, 1'b1, 8'sd0);
        vectors++;
        if (o_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_pulse: valid=%b, required 0", o_out_valid);
        end
    endtask

    task automatic check_queue(input string name, input logic signed [7:0] exp_q[$]);
        vectors++;
        if (q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_count: outputs=%0d, required %0d", name, q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q.size()) begin
                vectors++;
                if (q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: dout=%0d, required %0d", name, i, q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_echo_forward();
        logic signed [7:0] e[$];
        e = '{8'sd64, 8'sd32, 8'sd16, 8'sd8, 8'sd4, 8'sd2, 8'sd1, 8'sd0};
        i_mode = MODE_ECHO; i_delay = 4'd1; i_gain_shift = 3'd1;
        pulse_reset();
        apply(1'b1, 1'b1, 8'sd64);
        for (int k = 0; k < 7; k++) apply(1'b1, 1'b1, 8'sd0);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 8'sd0);
        check_queue("echo_fwd", e);
    endtask

    task automatic test_saturation();
        logic signed [7:0] e[$];
        e = '{8'sd127, -8'sd128, 8'sd40, -8'sd80, 8'sd7, -8'sd5, 8'sd33};
        i_mode = MODE_ECHO; i_delay = 4'd0; i_gain_shift = 3'd0;
        pulse_reset();
        apply(1'b1, 1'b1, 8'sd100);
        apply(1'b1, 1'b1, -8'sd100);
        apply(1'b1, 1'b1, 8'sd20);
        i_gain_shift = 3'd2;
        apply(1'b1, 1'b1, -8'sd64);
        i_mode = MODE_DELAY;
        apply(1'b1, 1'b1, 8'sd7);
        i_mode = MODE_BYPASS; i_delay = 4'd3;
        apply(1'b1, 1'b1, -8'sd5);
        i_mode = MODE_BYPASS3;
        apply(1'b1, 1'b1, 8'sd33);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 8'sd0);
        check_queue("sat", e);
    endtask

    task automatic test_wrap();
        logic signed [7:0] e[$];
        e = {};
        for (int n = 0; n < 40; n++) e.push_back((n < 15) ? 8'sd0 : 8'(n - 14));
        for (int n = 0; n < 5; n++) e.push_back(8'(50 + n));
        i_mode = MODE_DELAY; i_delay = 4'd15; i_gain_shift = 3'd0;
        pulse_reset();
        for (int n = 0; n < 40; n++) apply(1'b1, 1'b1, 8'(n + 1));
        i_delay = 4'd0;
        for (int n = 0; n < 5; n++) apply(1'b1, 1'b1, 8'(50 + n));
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 8'sd0);
        check_queue("wrap", e);
    endtask

    task automatic test_gaps_reset();
        logic signed [7:0] e[$];
        e = '{8'sd0, 8'sd0, 8'sd10, 8'sd13};
        i_mode = MODE_DELAY; i_delay = 4'd2; i_gain_shift = 3'd0;
        pulse_reset();
        for (int c = 0; c < 18; c++) apply((c % 3) == 0, (c % 9) != 6, 8'(c + 10));
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 8'sd0);
        check_queue("gaps", e);
        q.delete();
        apply(1'b1, 1'b1, 8'sd77);
        i_rst = 1'b1;
        apply(1'b0, 1'b1, 8'sd0);
        vectors++;
        if (o_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: valid=%b, required 0", o_out_valid);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 8'sd0);
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_dropped: outputs=%0d, required 0", q.size());
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_in_valid = 1'b0; i_din = 8'sd0;
        i_mode = MODE_DELAY; i_delay = 4'd0; i_gain_shift = 3'd0;
        test_reset();
        test_delay_ramp();
        test_echo_forward();
        test_saturation();
        test_wrap();
        test_gaps_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
